// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter that shares one combinational ALU
// between two valid/ready requesters. Each accepted result goes into a
// one-deep registered response buffer that has valid/ready backpressure.
// Optional feature: define ALU_ARB_OPCHECK_EN to flag illegal op codes.
// With the macro defined, illegal codes are accepted but return
// rsp_err=1 and rsp_data=0.
module alu_share_arb #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [4:0]   req0_aluc,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [4:0]   req1_aluc,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [W-1:0] alu_data1,
  output logic [W-1:0] alu_data2,
  output logic [4:0]   alu_aluc,
  input  logic [W-1:0] alu_rdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  buf_state_e   state_q;
  logic         last_id_q;
  logic         rsp_id_q;
  logic [W-1:0] rsp_data_q;
  logic         rsp_err_q;

  logic         can_accept;
  logic         any_valid;
  logic         grant_id;
  logic         accept;
  logic [4:0]   sel_aluc;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic         op_illegal;
  logic [W-1:0] rsp_data_d;

`ifdef ALU_ARB_OPCHECK_EN
  // Legal codes: 1-8, 10-15 and 18.
  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd18: op_legal = 1'b1;
      default:                                         op_legal = 1'b0;
    endcase
  endfunction
`endif

  // Round-robin grant, then operand selection from the granted requester.
  always_comb begin
    // NOTE: give every always_comb output a default first; otherwise any
    // path that leaves it unassigned infers a latch.
    can_accept = (state_q == EMPTY) || rsp_ready;
    any_valid  = req0_valid || req1_valid;
    grant_id   = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_id_q;
    else if (req1_valid)          grant_id = 1'b1;
    accept     = any_valid && can_accept;
    sel_aluc   = grant_id ? req1_aluc : req0_aluc;
    sel_a      = grant_id ? req1_a    : req0_a;
    sel_b      = grant_id ? req1_b    : req0_b;
`ifdef ALU_ARB_OPCHECK_EN
    op_illegal = !op_legal(sel_aluc);
`else
    op_illegal = 1'b0;
`endif
  end

  // Request handshake and ALU drive. The ALU inputs are zero whenever no
  // request is accepted, so the shared ALU sees no toggling.
  always_comb begin
    req0_ready = accept && !grant_id;
    req1_ready = accept &&  grant_id;
    alu_data1  = '0;
    alu_data2  = '0;
    alu_aluc   = '0;
    if (accept) begin
      alu_data1 = sel_a;
      alu_data2 = sel_b;
      alu_aluc  = op_illegal ? 5'd0 : sel_aluc;
    end
    rsp_data_d = op_illegal ? '0 : alu_rdata;
  end

  // Response buffer FSM: capture on accept, empty on drain without accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      last_id_q  <= 1'b1;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples its pre-edge value and ordering inside the block
      // does not matter.
      case (state_q)
        EMPTY: begin
          if (accept) state_q <= FULL;
        end
        FULL: begin
          if (rsp_ready && !accept) state_q <= EMPTY;
        end
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        rsp_data_q <= rsp_data_d;
        rsp_id_q   <= grant_id;
        rsp_err_q  <= op_illegal;
        last_id_q  <= grant_id;
      end
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed bench for alu_share_arb. It includes a small
// combinational ALU model that stands in for the shared EX-stage ALU.
// Build with ALU_ARB_OPCHECK_EN defined to exercise op-code checking.
module tb_alu_share_arb;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [4:0]   req0_aluc, req1_aluc;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] alu_data1, alu_data2;
  logic [4:0]   alu_aluc;
  logic [W-1:0] alu_rdata;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_data;

  int checks = 0;
  int errors = 0;

  alu_share_arb #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_aluc  (req0_aluc),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_aluc  (req1_aluc),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_data1  (alu_data1),
    .alu_data2  (alu_data2),
    .alu_aluc   (alu_aluc),
    .alu_rdata  (alu_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model: shift amount comes from data1, shifted value from data2.
  always_comb begin
    alu_rdata = '0;
    case (alu_aluc)
      5'd1, 5'd10, 5'd14, 5'd15: alu_rdata = alu_data1 + alu_data2;
      5'd2:                      alu_rdata = alu_data1 - alu_data2;
      5'd3, 5'd11:               alu_rdata = alu_data1 & alu_data2;
      5'd4, 5'd12:               alu_rdata = alu_data1 | alu_data2;
      5'd5, 5'd13:               alu_rdata = alu_data1 ^ alu_data2;
      5'd6:                      alu_rdata = alu_data2 << alu_data1[4:0];
      5'd7:                      alu_rdata = alu_data2 >> alu_data1[4:0];
      5'd8:                      alu_rdata = $unsigned($signed(alu_data2) >>> alu_data1[4:0]);
      5'd18:                     alu_rdata = alu_data2 << 16;
      default:                   alu_rdata = '0;
    endcase
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic       exp_id [4];
  logic [W-1:0] exp_data [4];

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_aluc = '0; req1_aluc = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_rsp_valid", W'(rsp_valid), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", W'(rsp_id), 0);
    check("rst_rsp_err", W'(rsp_err), 0);
    check("rst_alu_aluc", W'(alu_aluc), 0);
    rst = 1'b0;

    // req0 alone: add 5 + 7
    req0_valid = 1'b1; req0_aluc = 5'd1; req0_a = 5; req0_b = 7;
    rsp_ready = 1'b1;
    #1;
    check("t1_req0_ready", W'(req0_ready), 1);
    check("t1_req1_ready", W'(req1_ready), 0);
    check("t1_alu_data1", alu_data1, 5);
    check("t1_alu_aluc", W'(alu_aluc), 1);
    step();
    req0_valid = 1'b0;
    check("t1_rsp_valid", W'(rsp_valid), 1);
    check("t1_rsp_id", W'(rsp_id), 0);
    check("t1_rsp_data", rsp_data, 12);
    #1;
    check("idle_alu_data1", alu_data1, 0);
    step();
    check("drain_rsp_valid", W'(rsp_valid), 0);
    check("drain_rsp_data_hold", rsp_data, 12);

    // Both valid: last_id is 0, so req1 wins first and the grants alternate
    req0_valid = 1'b1; req0_aluc = 5'd2; req0_a = 10; req0_b = 3;
    req1_valid = 1'b1; req1_aluc = 5'd6; req1_a = 4;  req1_b = 1;
    exp_id[0] = 1'b1; exp_data[0] = 16;
    exp_id[1] = 1'b0; exp_data[1] = 7;
    exp_id[2] = 1'b1; exp_data[2] = 16;
    exp_id[3] = 1'b0; exp_data[3] = 7;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d_req1_ready", i), W'(req1_ready), W'(exp_id[i]));
      check($sformatf("rr%0d_req0_ready", i), W'(req0_ready), W'(!exp_id[i]));
      step();
      check($sformatf("rr%0d_rsp_valid", i), W'(rsp_valid), 1);
      check($sformatf("rr%0d_rsp_id", i), W'(rsp_id), W'(exp_id[i]));
      check($sformatf("rr%0d_rsp_data", i), rsp_data, exp_data[i]);
    end

    // Backpressure: the buffer is full and rsp_ready is low
    rsp_ready = 1'b0;
    #1;
    check("bp_req0_ready", W'(req0_ready), 0);
    check("bp_req1_ready", W'(req1_ready), 0);
    check("bp_alu_data1", alu_data1, 0);
    check("bp_alu_data2", alu_data2, 0);
    check("bp_alu_aluc", W'(alu_aluc), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp%0d_rsp_valid", i), W'(rsp_valid), 1);
      check($sformatf("bp%0d_rsp_data", i), rsp_data, 7);
      check($sformatf("bp%0d_rsp_id", i), W'(rsp_id), 0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_req1_ready", W'(req1_ready), 1);
    step();
    check("bp_release_rsp_valid", W'(rsp_valid), 1);
    check("bp_release_rsp_id", W'(rsp_id), 1);
    check("bp_release_rsp_data", rsp_data, 16);

    // Asynchronous reset while the buffer is full
    rsp_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("arst_rsp_valid", W'(rsp_valid), 0);
    check("arst_rsp_data", rsp_data, 0);
    check("arst_rsp_id", W'(rsp_id), 0);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("arst_first_req0_ready", W'(req0_ready), 1);
    check("arst_first_req1_ready", W'(req1_ready), 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("arst_first_rsp_id", W'(rsp_id), 0);
    check("arst_first_rsp_data", rsp_data, 7);

    // sra and lui
    req0_valid = 1'b1; req0_aluc = 5'd8; req0_a = 4; req0_b = 32'h8000_0000;
    step();
    check("sra_rsp_data", rsp_data, 32'hF800_0000);
    req0_aluc = 5'd18; req0_a = 0; req0_b = 32'h0000_1234;
    step();
    check("lui_rsp_data", rsp_data, 32'h1234_0000);
    check("lui_rsp_err", W'(rsp_err), 0);
    req0_valid = 1'b0;

    // Legal immediate form (code 10), then unsupported code 16 from req1
    req1_valid = 1'b1; req1_aluc = 5'd10; req1_a = 3; req1_b = 5;
    step();
    check("addi_rsp_data", rsp_data, 8);
    check("addi_rsp_err", W'(rsp_err), 0);
    req1_aluc = 5'd16;
    #1;
    check("bad_req1_ready", W'(req1_ready), 1);
`ifdef ALU_ARB_OPCHECK_EN
    check("bad_alu_aluc", W'(alu_aluc), 0);
`else
    check("bad_alu_aluc", W'(alu_aluc), 16);
`endif
    step();
    req1_valid = 1'b0;
    check("bad_rsp_valid", W'(rsp_valid), 1);
    check("bad_rsp_id", W'(rsp_id), 1);
    check("bad_rsp_data", rsp_data, 0);
`ifdef ALU_ARB_OPCHECK_EN
    check("bad_rsp_err", W'(rsp_err), 1);
`else
    check("bad_rsp_err", W'(rsp_err), 0);
`endif
    step();
    check("final_rsp_valid", W'(rsp_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
